uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_receiver_sync_fifo.sv | 77 +++++++
 rtl/uart_receiver.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_receiver.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver: receive FSM state encoding,
// oversample tick positions inside one bit period, frame width and the
// 2-of-3 majority helper used for data and stop bit decisions.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK_WAIT
  } rx_state_e;

  localparam int DATA_BITS = 8;

  // Tick positions (0..15) inside one 16x-oversampled bit period.
  localparam logic [3:0] TICK_EARLY = 4'd7;
  localparam logic [3:0] TICK_MID   = 4'd8;
  localparam logic [3:0] TICK_LATE  = 4'd9;
  localparam logic [3:0] TICK_LAST  = 4'd15;

  // Bit counter value of the last data bit. Value 0 means "tail of the
  // start bit", so data bits occupy counts 1..DATA_BITS.
  localparam logic [3:0] BIT_CNT_LAST = 4'(DATA_BITS);

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_receiver_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO used as receive storage when the design is built with
// the UART_RX_FIFO_EN macro; the module only exists in that build.
// A push while full is accepted if a pop happens in the same cycle.
// Ports:
//   clk, reset (async, active-low)
//   push / push_data   write request and data
//   pop  / pop_data    read request and head-of-queue data (0 when empty)
//   full, empty        status
//   count              entries currently stored (0..DEPTH)
// Parameters: WIDTH data width, DEPTH entries (power of two).
// ---------------------------------------------------------------------------
`ifdef UART_RX_FIFO_EN
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == DEPTH_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  // Head data is forced to zero while empty so the output is defined after reset.
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array carries no reset; its contents are only visible through
  // pop_data, which is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`endif

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
// 8N1 UART receiver with 16x oversampling, 2-of-3 majority voting on every
// data and stop bit, frame error detection with break wait, and receive
// storage with sticky overrun.
// Build option: define UART_RX_FIFO_EN for a FIFO of FIFO_DEPTH entries;
// without it storage is a single holding register (fifo_count is 0 or 1).
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   rx         asynchronous serial input, idle high, LSB first
//   rd_data    oldest received byte
//   rd_valid   rd_data holds a byte
//   rd_ready   consumer accepts rd_data when rd_valid && rd_ready
//   frame_err  one-cycle pulse on a bad stop bit
//   overrun    sticky: a byte was dropped because storage was full
//   clr_err    clears overrun on the next cycle
//   fifo_count bytes currently stored
// Parameters: CLK_DIV clk cycles per oversample tick (1..4095),
//             FIFO_DEPTH storage entries (power of two, 2..256).
// ---------------------------------------------------------------------------
module uart_receiver #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          clr_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  import uart_pkg::*;

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int DIV_W = 12;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Synchronizer and edge-detect history.
  logic rx_meta_q, rx_meta_d;
  logic rx_sync_q, rx_sync_d;
  logic rx_prev_q, rx_prev_d;

  rx_state_e            state_q, state_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [3:0]           samp_cnt_q, samp_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           samples_q, samples_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic tick;
  logic vote;
  logic push;
  logic pop;
  logic store_full;
  logic drop;

  assign tick = (div_cnt_q == DIV_LAST);
  // Third vote is the live sample taken at the late tick.
  assign vote = majority3(samples_q[0], samples_q[1], rx_sync_q);

  assign pop  = rd_valid && rd_ready;
  assign drop = push && store_full && !pop;

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  always_comb begin
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
  end

  // Receive FSM, tick divider and bit datapath. The divider and tick index
  // free-run and are restarted when a start edge is seen, so the first bit
  // period is aligned to the detected edge.
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
    samp_cnt_d  = tick ? samp_cnt_q + 1'b1 : samp_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    samples_d   = samples_q;
    push        = 1'b0;
    frame_err_d = 1'b0;

    if (tick && (state_q == ST_DATA || state_q == ST_STOP)) begin
      if (samp_cnt_q == TICK_EARLY) samples_d[0] = rx_sync_q;
      if (samp_cnt_q == TICK_MID)   samples_d[1] = rx_sync_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d    = ST_START;
          div_cnt_d  = '0;
          samp_cnt_d = '0;
        end
      end

      // Start bit is qualified by its mid sample. On success DATA is entered
      // with bit_cnt 0, which times out the rest of the start bit before the
      // first data bit is sampled.
      ST_START: begin
        if (tick && samp_cnt_q == TICK_MID) begin
          if (rx_sync_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (samp_cnt_q == TICK_LATE && bit_cnt_q != '0) begin
            shift_d = {vote, shift_q[DATA_BITS-1:1]};
          end
          if (samp_cnt_q == TICK_LAST) begin
            if (bit_cnt_q == BIT_CNT_LAST) begin
              state_d = ST_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end

      // Leaving at the late tick frees the second half of the stop bit so a
      // following start edge can be caught without an idle gap.
      ST_STOP: begin
        if (tick && samp_cnt_q == TICK_LATE) begin
          if (vote) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK_WAIT;
          end
        end
      end

      ST_BREAK_WAIT: begin
        if (rx_sync_q) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // A new drop wins over a simultaneous clear.
  always_comb begin
    overrun_d = (overrun_q && !clr_err) || drop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      samp_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      samples_q   <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      samp_cnt_q  <= samp_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      samples_q   <= samples_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shift_q),
    .pop       (pop),
    .pop_data  (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign store_full = fifo_full;
  assign rd_valid   = !fifo_empty;
`else
  logic                 hold_valid_q, hold_valid_d;
  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
  logic                 hold_accept;

  // Same acceptance rule as the FIFO: a full register takes a new byte only
  // when the current one is consumed in the same cycle.
  assign hold_accept = push && (!hold_valid_q || pop);

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (pop) hold_valid_d = 1'b0;
    if (hold_accept) begin
      hold_valid_d = 1'b1;
      hold_data_d  = shift_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

  assign store_full = hold_valid_q;
  assign rd_valid   = hold_valid_q;
  assign rd_data    = hold_data_q;
  assign fifo_count = {{(CW-1){1'b0}}, hold_valid_q};
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
// Directed bench for uart_receiver (CLK_DIV=4, 64 clk per bit). A serial
// driver builds 8N1 frames; a negedge monitor records consumed bytes,
// frame_err pulses and rd_valid activity; every comparison goes through
// checkOutput. Storage depth expectations follow UART_RX_FIFO_EN.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 16;
  localparam int BIT_CLKS   = 16 * CLK_DIV;
`ifdef UART_RX_FIFO_EN
  localparam int EFF_DEPTH  = FIFO_DEPTH;
`else
  localparam int EFF_DEPTH  = 1;
`endif

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       frame_err;
  logic       overrun;
  logic       clr_err;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  uart_receiver #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .clr_err    (clr_err),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycleCnt    = 0;
  int startCycle  = 0;
  int nextRx      = 0;

  logic [7:0] rxQ[$];
  int   feCount     = 0;
  int   validCycles = 0;
  int   lastRise    = 0;
  logic prevValid   = 1'b0;

  // Free-running cycle counter used to time-stamp frames and rd_valid.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Monitor sampling away from the active edge.
  always @(negedge clk) begin
    if (rd_valid && rd_ready) rxQ.push_back(rd_data);
    if (frame_err) feCount <= feCount + 1;
    if (rd_valid) validCycles <= validCycles + 1;
    if (rd_valid && !prevValid) lastRise <= cycleCnt;
    prevValid <= rd_valid;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame. glitch inverts rx for one clock near the middle of
  // every data and stop bit. abortBit >= 0 pulses reset in the middle of that
  // data bit and abandons the rest of the frame.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                               input bit glitch, input int abortBit);
    logic [9:0] frame;
    frame = {stopBit, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < BIT_CLKS; c++) begin
        @(posedge clk);
        #1;
        if (b == 0 && c == 0) startCycle = cycleCnt;
        if (abortBit >= 0 && b == abortBit + 1 && c == BIT_CLKS / 2) begin
          reset = 1'b0;
          rx    = 1'b1;
          repeat (5) @(posedge clk);
          #1;
          reset = 1'b1;
          return;
        end
        rx = frame[b];
        if (glitch && b >= 1 && c == 36) rx = ~frame[b];
      end
    end
  endtask

  task automatic expectByte(input string tag, input logic [7:0] exp);
    logic [31:0] got;
    if (nextRx < rxQ.size()) begin
      got = 32'(rxQ[nextRx]);
      nextRx++;
    end else begin
      got = 32'hFFFF_FFFF;
    end
    checkOutput(tag, got, 32'(exp));
  endtask

  initial begin
    int q0;
    int v0;
    int fe0;
    int lat;

    reset    = 1'b0;
    rx       = 1'b1;
    rd_ready = 1'b0;
    clr_err  = 1'b0;

    // Reset values while reset is held.
    #12;
    checkOutput("reset_rd_valid",   32'(rd_valid),   32'd0);
    checkOutput("reset_rd_data",    32'(rd_data),    32'd0);
    checkOutput("reset_frame_err",  32'(frame_err),  32'd0);
    checkOutput("reset_overrun",    32'(overrun),    32'd0);
    checkOutput("reset_fifo_count", 32'(fifo_count), 32'd0);
    idle(3);
    reset = 1'b1;
    idle(20);

    // Single byte: rd_valid rises during the second half of the stop bit
    // (stop bit spans 576..640 clk after the start edge) and lasts one cycle.
    rd_ready = 1'b1;
    q0 = rxQ.size();
    v0 = validCycles;
    applyStimulus(8'h2D, 1'b1, 1'b0, -1);
    idle(100);
    checkOutput("byte2d_count", rxQ.size() - q0, 32'd1);
    expectByte("byte2d_data", 8'h2D);
    checkOutput("byte2d_valid_cycles", validCycles - v0, 32'd1);
    lat = lastRise - startCycle;
    checkOutput("byte2d_latency_window", 32'(lat >= 9 * BIT_CLKS + BIT_CLKS / 2 - 8 &&
                                             lat <= 10 * BIT_CLKS), 32'd1);

    // Short low pulse is rejected as a false start.
    q0  = rxQ.size();
    fe0 = feCount;
    rx  = 1'b0;
    idle(20);
    rx  = 1'b1;
    idle(200);
    checkOutput("glitch_no_byte", rxQ.size() - q0, 32'd0);
    checkOutput("glitch_no_ferr", feCount - fe0, 32'd0);
    applyStimulus(8'h96, 1'b1, 1'b0, -1);
    idle(100);
    expectByte("after_glitch_byte", 8'h96);

    // Bad stop bit: one frame_err pulse, nothing stored, next frame fine.
    q0  = rxQ.size();
    fe0 = feCount;
    applyStimulus(8'h53, 1'b0, 1'b0, -1);
    rx = 1'b1;
    idle(100);
    checkOutput("ferr_pulses", feCount - fe0, 32'd1);
    checkOutput("ferr_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("ferr_no_byte", rxQ.size() - q0, 32'd0);
    checkOutput("ferr_low_after", 32'(frame_err), 32'd0);
    applyStimulus(8'hA5, 1'b1, 1'b0, -1);
    idle(100);
    expectByte("after_ferr_byte", 8'hA5);

    // Fill storage without consuming, one frame more than it can hold.
    rd_ready = 1'b0;
    for (int i = 0; i <= FIFO_DEPTH; i++) applyStimulus(8'(i), 1'b1, 1'b0, -1);
    idle(100);
    checkOutput("full_fifo_count", 32'(fifo_count), 32'(EFF_DEPTH));
    checkOutput("full_overrun", 32'(overrun), 32'd1);
    checkOutput("full_rd_valid", 32'(rd_valid), 32'd1);
    checkOutput("full_head_stable", 32'(rd_data), 32'h00);
    rd_ready = 1'b1;
    idle(EFF_DEPTH + 10);
    for (int i = 0; i < EFF_DEPTH; i++) expectByte("drain_byte", 8'(i));
    checkOutput("drain_extra", rxQ.size() - nextRx, 32'd0);
    checkOutput("drain_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("overrun_sticky", 32'(overrun), 32'd1);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    idle(1);
    checkOutput("overrun_cleared", 32'(overrun), 32'd0);

    // Back-to-back glitched frames.
    fe0 = feCount;
    applyStimulus(8'h55, 1'b1, 1'b1, -1);
    applyStimulus(8'hAA, 1'b1, 1'b1, -1);
    applyStimulus(8'hFF, 1'b1, 1'b1, -1);
    idle(100);
    expectByte("b2b_byte0", 8'h55);
    expectByte("b2b_byte1", 8'hAA);
    expectByte("b2b_byte2", 8'hFF);
    checkOutput("b2b_no_ferr", feCount - fe0, 32'd0);

    // Reset in the middle of data bit 4 abandons the frame silently.
    q0  = rxQ.size();
    fe0 = feCount;
    applyStimulus(8'h3C, 1'b1, 1'b0, 4);
    rx = 1'b1;
    idle(100);
    checkOutput("rst_mid_no_byte", rxQ.size() - q0, 32'd0);
    checkOutput("rst_mid_no_ferr", feCount - fe0, 32'd0);
    checkOutput("rst_mid_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_mid_rd_valid", 32'(rd_valid), 32'd0);
    applyStimulus(8'h3C, 1'b1, 1'b0, -1);
    idle(100);
    expectByte("rst_mid_retry_byte", 8'h3C);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
